// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int WORD_BITS = 32;

  function automatic logic is_signed_src1(mdu_op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_src2(mdu_op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(mdu_op_t op);
    return op inside {REM, REMU};
  endfunction

  // High-half multiplies have no word form; the word flag is ignored for them.
  function automatic logic is_mul_high(mdu_op_t op);
    return op inside {MULH, MULHSU, MULHU};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it did not borrow.
// Relies on the invariant rem < divisor, which holds from a zero start.
module mdu_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic         in_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted  = {rem, in_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[W];
  assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one accumulator, behind valid/ready handshakes.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit WORD_OPS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = $clog2(XLEN);

  // Sign-extend a word result from bit 31 when in word mode.
  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] x, input logic word);
    logic [XLEN-1:0] r;
    r = x;
    if (word) for (int i = WORD_BITS; i < XLEN; i++) r[i] = x[WORD_BITS-1];
    return r;
  endfunction

  // Widen the low 32 bits, sign- or zero-extending.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = WORD_BITS; i < XLEN; i++) r[i] = sgn & x[WORD_BITS-1];
    return r;
  endfunction

  mdu_state_t        state_reg, state_next;
  logic [2*XLEN-1:0] acc_reg, mcand_reg;
  logic [XLEN-1:0]   opb_reg, result_reg;
  logic [CW-1:0]     cnt_reg;
  mdu_op_t           op_reg;
  logic              word_reg, neg_reg;

  mdu_op_t           op_in;
  logic              s1_in, word_in, sign_a, sign_b, div_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, min_val, special_result;

  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, remd, calc_result, step_rem;
  logic              step_q;

  // Operand preparation, special-case detection and sign bookkeeping for a new request.
  always_comb begin
    op_in    = mdu_op_t'(in_op);
    s1_in    = is_signed_src1(op_in);
    word_in  = WORD_OPS && in_word && !is_mul_high(op_in);
    a_ext    = word_in ? ext32(in_src1, s1_in) : in_src1;
    b_ext    = word_in ? ext32(in_src2, is_signed_src2(op_in)) : in_src2;
    sign_a   = s1_in && a_ext[XLEN-1];
    sign_b   = is_signed_src2(op_in) && b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    min_val  = fmt(XLEN'(1) << (word_in ? WORD_BITS - 1 : XLEN - 1), word_in);
    div_zero = (b_ext == '0);
    div_ovf  = s1_in && (a_ext == min_val) && (b_ext == '1);
    special  = is_div(op_in) && (div_zero || div_ovf);
    if (is_rem(op_in)) special_result = div_zero ? a_ext : '0;
    else               special_result = div_zero ? '1 : a_ext;
    special_result = fmt(special_result, word_in);
    neg_in = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
  end

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem      (acc_reg[2*XLEN-1:XLEN]),
    .in_bit   (acc_reg[XLEN-1]),
    .divisor  (opb_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // One iteration of the active operation plus the sign fixup of its outcome.
  always_comb begin
    if (is_div(op_reg)) acc_step = {step_rem, acc_reg[XLEN-2:0], step_q};
    else                acc_step = acc_reg + (opb_reg[0] ? mcand_reg : '0);
    prod = neg_reg ? -acc_step : acc_step;
    quo  = neg_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    remd = neg_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_reg)
      MUL:                 calc_result = fmt(prod[XLEN-1:0], word_reg);
      MULH, MULHSU, MULHU: calc_result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           calc_result = fmt(quo, word_reg);
      default:             calc_result = fmt(remd, word_reg);
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = special ? DONE : CALC;
      end
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC, capture the final result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      op_reg     <= MUL;
      word_reg   <= 1'b0;
      neg_reg    <= 1'b0;
    end else if (!flush) begin
      if (state_reg == IDLE && in_valid) begin
        op_reg     <= op_in;
        word_reg   <= word_in;
        neg_reg    <= neg_in;
        cnt_reg    <= word_in ? CW'(WORD_BITS - 1) : CW'(XLEN - 1);
        opb_reg    <= mag_b;
        result_reg <= special ? special_result : '0;
        if (is_div(op_in)) begin
          // Left-align the dividend so its top bit is shifted out first.
          acc_reg   <= {{XLEN{1'b0}}, mag_a << (word_in ? XLEN - WORD_BITS : 0)};
          mcand_reg <= '0;
        end else begin
          acc_reg   <= '0;
          mcand_reg <= {{XLEN{1'b0}}, mag_a};
        end
      end else if (state_reg == CALC) begin
        acc_reg   <= acc_step;
        mcand_reg <= mcand_reg << 1;
        if (!is_div(op_reg)) opb_reg <= opb_reg >> 1;
        cnt_reg   <= cnt_reg - CW'(1);
        if (cnt_reg == '0) result_reg <= calc_result;
      end
    end
  end

  assign out_result = result_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic reference model plus scoreboard
// monitor checking every result cycle, latency, and handshake behaviour.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc_cyc;
    bit          seen;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] lit;
  } vec_t;
  vec_t vecs[12];

  mdu_iter #(.XLEN(64), .WORD_OPS(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] sx32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  // Reference: RISC-V M semantics computed with wide arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a_in, input logic [63:0] b_in,
                                        output int lat);
    logic [127:0] ea, eb, p;
    logic [63:0]  a, b, q, r, res;
    logic         sa, sb, word;
    sa   = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    sb   = op inside {3'd0, 3'd1, 3'd4, 3'd6};
    word = w && !(op inside {3'd1, 3'd2, 3'd3});
    a = a_in;
    b = b_in;
    lat = (word ? 32 : 64) + 1;
    if (op < 3'd4) begin
      ea = sa ? {{64{a[63]}}, a} : {64'b0, a};
      eb = sb ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ea * eb;
      if (op == 3'd0) return word ? sx32(p[63:0]) : p[63:0];
      return p[127:64];
    end
    if (word) begin
      a = sa ? sx32(a) : {32'b0, a[31:0]};
      b = sa ? sx32(b) : {32'b0, b[31:0]};
    end
    if (b == 64'd0) begin
      q = '1; r = a; lat = 1;
    end else if (sa && b == '1 && a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = a; r = '0; lat = 1;
    end else if (sa) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    res = (op == 3'd6 || op == 3'd7) ? r : q;
    return word ? sx32(res) : res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: records accepts, checks result, latency and in_ready while out_valid.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (in_valid && in_ready && !flush && exp_q.size() > 0)
          exp_q[exp_q.size()-1].acc_cyc = cyc;
        if (out_valid) begin
          check("in_ready_in_done", {63'b0, in_ready}, 64'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
          end else begin
            check("result", out_result, exp_q[0].res);
            if (!exp_q[0].seen) begin
              exp_q[0].seen = 1;
              check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
            end
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int   lat;
    e.res = model(op, w, a, b, lat);
    e.lat = lat;
    e.acc_cyc = 0;
    e.seen = 0;
    exp_q.push_back(e);
    in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int hold, input logic [63:0] lit);
    int t;
    out_ready = (hold == 0);
    start_op(op, w, a, b);
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    if (!out_valid) begin
      check({name, "_timeout"}, {63'b0, out_valid}, 64'd1);
      exp_q.delete();
      return;
    end
    check(name, out_result, lit);
    $display("op=%0d word=%0d a=%h b=%h result=%h", op, w, a, b, out_result);
    if (hold > 0) begin
      repeat (hold) @(posedge clock);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[1]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{3'd7, 1'b0, 64'd17, 64'd5, 64'd2};
    vecs[3]  = '{3'd6, 1'b1, 64'h1234_5678_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001};
    vecs[4]  = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
    vecs[5]  = '{3'd7, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd7, 64'd2};
    vecs[6]  = '{3'd3, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'd2};
    vecs[7]  = '{3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555};
    vecs[8]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[9]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[10] = '{3'd2, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[11] = '{3'd5, 1'b1, 64'hABCD_0000_8000_0000, 64'h0000_0005_0000_0001, 64'hFFFF_FFFF_8000_0000};

    // Reset state.
    #1;
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_out_result", out_result, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // Directed vectors from the plan.
    run_op("mul_neg", MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mulhu_max", MULHU, 1'b0, '1, '1, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu_m1", MULHSU, 1'b0, '1, '1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 64'h8000_0000_0000_0000);
    run_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 64'd0);
    run_op("divu_zero", DIVU, 1'b0, 64'd123, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_zero", REMU, 1'b0, 64'd5, 64'd0, 0, 64'd5);
    run_op("divw", DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("remw", REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divuw", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Further operand patterns and word/special corners.
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 0, vecs[i].lit);

    // Back-pressure: result held for 10 cycles, monitor checks each cycle.
    run_op("backpressure", DIVU, 1'b0, 64'd1000, 64'd3, 10, 64'd333);

    // Request presented together with flush in IDLE is not accepted.
    in_op = MUL; in_src1 = 64'd9; in_src2 = 64'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Flush in the middle of CALC.
    start_op(MUL, 1'b0, 64'd11, 64'd13);
    repeat (19) @(posedge clock);
    #1 flush = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (70) @(posedge clock);
    #1;
    run_op("mul_after_flush", MUL, 1'b0, 64'd6, 64'd7, 0, 64'd42);

    // Reset in the middle of CALC.
    start_op(DIV, 1'b0, 64'd1000000, 64'd3);
    repeat (20) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    check("midreset_out_result", out_result, 64'd0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    run_op("div_after_reset", DIV, 1'b0, 64'd100, 64'd7, 0, 64'd14);
    run_op("rem_after_reset", REM, 1'b0, 64'd100, 64'd7, 0, 64'd2);

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
